prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 175 +++++++++++++++++
 tb/tb_prog_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: unpacks a framed byte stream (count, words, XOR checksum)
// into program RAM writes, holding the CPU off via busy while a load is in flight.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned REG_BIT_CNT    = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned COMBINED_DATA  = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH,
  parameter int unsigned BYTES_PER_WORD = (COMBINED_DATA + 7) / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [COMBINED_DATA-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // Word counters must hold the count N itself (up to 2^ADDR_WIDTH) and any 8-bit header.
  localparam int unsigned CntW     = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;
  localparam int unsigned ByteIdxW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(BYTES_PER_WORD - 1);
  localparam logic [CntW-1:0]     MaxWords = CntW'(32'd1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StWrite,
    StCheck,
    StDone
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          n_q, n_d;
  logic [CntW-1:0]          word_idx_q, word_idx_d;
  logic [ByteIdxW-1:0]      byte_idx_q, byte_idx_d;
  logic [COMBINED_DATA-1:0] word_q, word_d;
  logic [7:0]               csum_q, csum_d;
  logic                     err_q, err_d;

  logic hs;
  logic hdr_too_long;
  logic last_word;

  assign hs           = in_valid & in_ready;
  assign hdr_too_long = CntW'(in_data) > MaxWords;
  assign last_word    = (word_idx_q == n_q - CntW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StHeader;
      end
      StHeader: begin
        if (hs) begin
          if (hdr_too_long)         state_d = StDone;
          else if (in_data == 8'h0) state_d = StCheck;
          else                      state_d = StData;
        end
      end
      StData: begin
        if (hs && byte_idx_q == LastByte) state_d = StWrite;
      end
      StWrite: begin
        state_d = last_word ? StCheck : StData;
      end
      StCheck: begin
        if (hs) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
    end
  end

  // Datapath next-state
  always_comb begin
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end
      StHeader: begin
        if (hs) begin
          n_d = CntW'(in_data);
          if (hdr_too_long) err_d = 1'b1;
        end
      end
      StData: begin
        if (hs) begin
          // Shifting through a COMBINED_DATA-wide register drops the excess high bits for free.
          word_d     = COMBINED_DATA'({word_q, in_data});
          csum_d     = csum_q ^ in_data;
          byte_idx_d = (byte_idx_q == LastByte) ? '0 : byte_idx_q + ByteIdxW'(1);
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + CntW'(1);
      end
      StCheck: begin
        if (hs && in_data != csum_q) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle:   busy     = 1'b0;
      StHeader: in_ready = 1'b1;
      StData:   in_ready = 1'b1;
      StWrite:  wr_en    = 1'b1;
      StCheck:  in_ready = 1'b1;
      StDone:   done     = 1'b1;
      default:  busy     = 1'b0;
    endcase
    wr_addr = word_idx_q[ADDR_WIDTH-1:0];
    wr_data = word_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized bench for prog_loader; expected RAM writes and error flags come
// from a frame-level model of the byte protocol.
module tb_prog_loader;

  localparam int Depth = 16;
  localparam logic [15:0] WordMask = 16'h3FFF;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [13:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt;

  logic [31:0] exp_words[$];
  logic        exp_err;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(32'(wr_addr));
      got_data.push_back(32'(wr_data));
      check("rdy_low_in_write", 32'(in_ready), 32'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Frame-level reference: header N, N big-endian 2-byte words, XOR checksum byte.
  task automatic model(input bq_t fr);
    int n;
    logic [7:0]  x;
    logic [15:0] w;
    n = int'(fr[0]);
    x = 8'h00;
    exp_words.delete();
    if (n > Depth) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {fr[1 + 2 * i], fr[2 + 2 * i]};
      exp_words.push_back(32'(w & WordMask));
      x = x ^ fr[1 + 2 * i] ^ fr[2 + 2 * i];
    end
    exp_err = (fr[1 + 2 * n] != x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int guard;
    guard = 0;
    while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rdy_when_offered", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // start_at: byte index before which a stray start is pulsed (-1 = none)
  task automatic run_frame(input bq_t fr, input int stall_pct, input int start_at);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    model(fr);
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("rdy_after_start", 32'(in_ready), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == start_at) begin
        pulse_start();
        check("busy_stray_start", 32'(busy), 32'd1);
      end
      send_byte(fr[i], stall_pct);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("err_final", 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("err_sticky", 32'(err), 32'(exp_err));
    check("write_count", 32'(got_data.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_data.size(); i++) begin
      check("wr_addr", got_addr[i], 32'(i));
      check("wr_data", got_data[i], exp_words[i]);
    end
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    bq_t fr;
    int n;
    logic [7:0] x;
    logic [7:0] b;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_rdy", 32'(in_ready), 32'd0);

    // Nominal load
    fr = '{8'h02, 8'h2A, 8'h5B, 8'hFF, 8'h01, 8'h8F};
    run_frame(fr, 0, -1);
    check("nom_w0", got_data.size() > 0 ? got_data[0] : 32'hDEAD, 32'h2A5B);
    check("nom_w1", got_data.size() > 1 ? got_data[1] : 32'hDEAD, 32'h3F01);
    check("nom_err", 32'(err), 32'd0);

    // Bad checksum
    fr = '{8'h02, 8'h2A, 8'h5B, 8'hFF, 8'h01, 8'h00};
    run_frame(fr, 0, -1);
    check("badck_err", 32'(err), 32'd1);

    // Length error: DONE straight after the header
    fr = '{8'h11};
    run_frame(fr, 0, -1);

    // Zero length
    fr = '{8'h00, 8'h00};
    run_frame(fr, 0, -1);

    // Stalled nominal load
    fr = '{8'h02, 8'h2A, 8'h5B, 8'hFF, 8'h01, 8'h8F};
    run_frame(fr, 50, -1);

    // Stray start during DATA
    run_frame(fr, 0, 2);

    // Reset after the first data byte
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h2A, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_data", 32'(wr_data), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_write", 32'(got_data.size()), 32'd0);

    // Fresh load after reset
    run_frame(fr, 0, -1);

    // Randomized frames, including full depth and just-over-depth headers
    for (int it = 0; it < 24; it++) begin
      if (it == 0)      n = Depth;
      else if (it == 1) n = Depth + 1;
      else              n = $urandom_range(0, Depth + 2);
      fr.delete();
      fr.push_back(8'(n));
      if (n <= Depth) begin
        x = 8'h00;
        for (int k = 0; k < 2 * n; k++) begin
          b = 8'($urandom());
          fr.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(3) == 0) x = x ^ 8'(1 << $urandom_range(7));
        fr.push_back(x);
      end
      run_frame(fr, int'($urandom_range(0, 60)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
